// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
//  Module : mem_arbiter_pkg
//  Brief  : Shared definitions for mem_arbiter. Holds the FSM state encoding,
//           the byte-lane select constants and the word-address helpers.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    // Bus FSM: LO is the first (or only) bus phase, HI the second half of an
    // odd-address word access, DONE the single rdy-pulse cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    // Byte-lane selects: SEL_LO = bits [7:0], SEL_HI = bits [15:8].
    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b11;

    // Word address of a byte address. IO space only decodes [15:0].
    function automatic logic [18:0] word_adr(input logic [19:0] byte_addr,
                                             input logic        io);
        if (io) begin
            return {4'b0000, byte_addr[15:1]};
        end
        return byte_addr[19:1];
    endfunction

    // Following word address. Memory wraps over 19 bits; IO wraps in 16-bit
    // byte space, i.e. the word index stays inside 15 bits.
    function automatic logic [18:0] next_word_adr(input logic [18:0] adr,
                                                  input logic        io);
        if (io) begin
            return {4'b0000, adr[14:0] + 15'd1};
        end
        return adr + 19'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module : mem_arbiter
//  Brief  : Shares one 16-bit Wishbone-classic bus between the exec data port
//           and instruction fetch. Splits odd-address word accesses into two
//           byte-lane bus phases and returns one rdy pulse per request.
//  Ports  : clk, rst (sync, active-high)
//           ex_*  : exec request in (req/we/m_io/byte/addr/wdata),
//                   ex_rdata/ex_rdy out
//           if_*  : fetch request in (req/addr), if_rdata/if_rdy out
//           wb_*  : Wishbone master (adr/dat/sel/we/tgc/cyc/stb out,
//                   dat_i/ack_i in)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit EXEC_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req,
    input  logic        ex_we,
    input  logic        ex_m_io,
    input  logic        ex_byte,
    input  logic [19:0] ex_addr,
    input  logic [15:0] ex_wdata,
    output logic [15:0] ex_rdata,
    output logic        ex_rdy,
    input  logic        if_req,
    input  logic [19:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_rdy,
    output logic [18:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_tgc_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    arb_state_e  state_q,  state_d;
    logic        gnt_ex_q, gnt_ex_d;   // 1 = current transfer belongs to exec
    logic        split_q,  split_d;    // odd-address word: needs HI phase
    logic        a0_q,     a0_d;       // byte address bit 0 of the request
    logic        byte_q,   byte_d;
    logic [7:0]  wd_hi_q,  wd_hi_d;    // write byte sent in the HI phase
    logic [18:0] adr_q,    adr_d;
    logic [15:0] dat_q,    dat_d;
    logic [1:0]  sel_q,    sel_d;
    logic        we_q,     we_d;
    logic        tgc_q,    tgc_d;
    logic        cyc_q,    cyc_d;
    logic [15:0] rdata_q,  rdata_d;
    logic        ex_rdy_q, ex_rdy_d;
    logic        if_rdy_q, if_rdy_d;

    // Request selection (only consulted in IDLE).
    logic        ex_win, if_win;
    logic [19:0] req_addr;
    logic [15:0] req_wd;
    logic        req_io, req_byte, req_we;

    always_comb begin
        ex_win   = ex_req & (EXEC_PRIO | ~if_req);
        if_win   = if_req & ~ex_win;
        // Fetch is always an aligned-or-split word read in memory space.
        req_addr = ex_win ? ex_addr : if_addr;
        req_wd   = ex_win ? ex_wdata : 16'h0000;
        req_io   = ex_win & ex_m_io;
        req_byte = ex_win & ex_byte;
        req_we   = ex_win & ex_we;
    end

    always_comb begin
        state_d  = state_q;
        gnt_ex_d = gnt_ex_q;
        split_d  = split_q;
        a0_d     = a0_q;
        byte_d   = byte_q;
        wd_hi_d  = wd_hi_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        tgc_d    = tgc_q;
        cyc_d    = cyc_q;
        rdata_d  = rdata_q;
        ex_rdy_d = 1'b0;
        if_rdy_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_win | if_win) begin
                    state_d  = ST_LO;
                    gnt_ex_d = ex_win;
                    a0_d     = req_addr[0];
                    byte_d   = req_byte;
                    split_d  = ~req_byte & req_addr[0];
                    wd_hi_d  = req_wd[15:8];
                    adr_d    = word_adr(req_addr, req_io);
                    we_d     = req_we;
                    tgc_d    = req_io;
                    cyc_d    = 1'b1;
                    // Bytes and the low half of a split word both ride on the
                    // lane picked by a[0]; the write byte is mirrored to both.
                    if (req_byte | req_addr[0]) begin
                        sel_d = req_addr[0] ? SEL_HI : SEL_LO;
                        dat_d = {req_wd[7:0], req_wd[7:0]};
                    end else begin
                        sel_d = SEL_W;
                        dat_d = req_wd;
                    end
                end
            end

            ST_LO: begin
                if (wb_ack_i) begin
                    if (split_q) begin
                        // cyc/stb stay up; only address, lane and data move.
                        state_d       = ST_HI;
                        adr_d         = next_word_adr(adr_q, tgc_q);
                        sel_d         = SEL_LO;
                        dat_d         = {wd_hi_q, wd_hi_q};
                        rdata_d[7:0]  = wb_dat_i[15:8];
                    end else begin
                        state_d  = ST_DONE;
                        cyc_d    = 1'b0;
                        ex_rdy_d = gnt_ex_q;
                        if_rdy_d = ~gnt_ex_q;
                        if (byte_q) begin
                            rdata_d = {8'h00, a0_q ? wb_dat_i[15:8] : wb_dat_i[7:0]};
                        end else begin
                            rdata_d = wb_dat_i;
                        end
                    end
                end
            end

            ST_HI: begin
                if (wb_ack_i) begin
                    state_d       = ST_DONE;
                    cyc_d         = 1'b0;
                    ex_rdy_d      = gnt_ex_q;
                    if_rdy_d      = ~gnt_ex_q;
                    rdata_d[15:8] = wb_dat_i[7:0];
                end
            end

            // Requests are deliberately not looked at here, so a requester
            // still holding req during its rdy cycle is not served twice.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_ex_q <= 1'b0;
            split_q  <= 1'b0;
            a0_q     <= 1'b0;
            byte_q   <= 1'b0;
            wd_hi_q  <= 8'h00;
            adr_q    <= 19'h0;
            dat_q    <= 16'h0000;
            sel_q    <= 2'b00;
            we_q     <= 1'b0;
            tgc_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rdata_q  <= 16'h0000;
            ex_rdy_q <= 1'b0;
            if_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_ex_q <= gnt_ex_d;
            split_q  <= split_d;
            a0_q     <= a0_d;
            byte_q   <= byte_d;
            wd_hi_q  <= wd_hi_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            tgc_q    <= tgc_d;
            cyc_q    <= cyc_d;
            rdata_q  <= rdata_d;
            ex_rdy_q <= ex_rdy_d;
            if_rdy_q <= if_rdy_d;
        end
    end

    // One read-data register serves both requesters; it is only meaningful
    // in the cycle the matching rdy is high.
    assign ex_rdata = rdata_q;
    assign if_rdata = rdata_q;
    assign ex_rdy   = ex_rdy_q;
    assign if_rdy   = if_rdy_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_tgc_o = tgc_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module : tb_mem_arbiter
//  Brief  : Scoreboard bench for mem_arbiter with a small Wishbone memory
//           model (programmable ack delay) and a second EXEC_PRIO=0 instance
//           for the priority-order case.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ex_req = 1'b0, ex_we = 1'b0, ex_m_io = 1'b0, ex_byte = 1'b0;
    logic [19:0] ex_addr = '0;
    logic [15:0] ex_wdata = '0;
    logic [15:0] ex_rdata;
    logic        ex_rdy;
    logic        if_req = 1'b0;
    logic [19:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_rdy;
    logic [18:0] wb_adr_o;
    logic [15:0] wb_dat_o, wb_dat_i;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o, wb_tgc_o, wb_cyc_o, wb_stb_o, wb_ack_i;

    mem_arbiter #(.EXEC_PRIO(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .ex_req(ex_req), .ex_we(ex_we), .ex_m_io(ex_m_io), .ex_byte(ex_byte),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rdata(ex_rdata), .ex_rdy(ex_rdy),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rdy(if_rdy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_tgc_o(wb_tgc_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    // Fetch-priority instance: shares request attributes, own req/bus.
    logic        b_ex_req = 1'b0, b_if_req = 1'b0;
    logic [15:0] b_ex_rdata, b_if_rdata, b_dat_o;
    logic        b_ex_rdy, b_if_rdy, b_we, b_tgc, b_cyc, b_stb, b_ack;
    logic [18:0] b_adr;
    logic [1:0]  b_sel;
    assign b_ack = b_cyc & b_stb;

    mem_arbiter #(.EXEC_PRIO(1'b0)) u_dut_fp (
        .clk(clk), .rst(rst),
        .ex_req(b_ex_req), .ex_we(ex_we), .ex_m_io(ex_m_io), .ex_byte(ex_byte),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rdata(b_ex_rdata), .ex_rdy(b_ex_rdy),
        .if_req(b_if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_rdy(b_if_rdy),
        .wb_adr_o(b_adr), .wb_dat_o(b_dat_o), .wb_dat_i(16'h0000),
        .wb_sel_o(b_sel), .wb_we_o(b_we), .wb_tgc_o(b_tgc),
        .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_ack_i(b_ack)
    );

    // ---------------- memory slave model ----------------
    logic [15:0] mem [0:1023];
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    assign wb_ack_i = wb_cyc_o && wb_stb_o && (wait_cnt >= ack_delay);
    assign wb_dat_i = mem[wb_adr_o[9:0]];

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) begin
            if (wb_sel_o[0]) mem[wb_adr_o[9:0]][7:0]  <= wb_dat_o[7:0];
            if (wb_sel_o[1]) mem[wb_adr_o[9:0]][15:8] <= wb_dat_o[15:8];
        end
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
        else                                   wait_cnt <= 0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [18:0] adr;
        logic [1:0]  sel;
        logic        we;
        logic        tgc;
        logic [15:0] dat;
    } phase_t;

    typedef struct {
        bit          is_ex;
        bit          chk;
        logic [15:0] rdata;
    } result_t;

    phase_t  exp_ph[$];
    result_t exp_res[$];
    int      n_checks = 0;
    int      n_errors = 0;
    bit      sb_en = 1'b1;
    int      n_starts = 0;
    int      n_rdy = 0;
    logic    prev_cyc = 1'b0, prev_ex_rdy = 1'b0, prev_if_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] sel);
        return {{8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Expected bus phases and result for one request, from the lane rules.
    task automatic push_expect(input bit is_ex, input bit we, input bit io, input bit byt,
                               input logic [19:0] a, input logic [15:0] wd);
        phase_t      p0, p1;
        result_t     r;
        logic [14:0] io_w;
        logic [18:0] w0, w1;
        logic [15:0] m0, m1;
        io_w = a[15:1];
        w0 = io ? {4'b0000, io_w} : a[19:1];
        w1 = io ? {4'b0000, io_w + 15'd1} : a[19:1] + 19'd1;
        m0 = mem[w0[9:0]];
        m1 = mem[w1[9:0]];
        p0.adr = w0; p0.we = we; p0.tgc = io;
        p1.adr = w1; p1.we = we; p1.tgc = io;
        r.is_ex = is_ex;
        r.chk   = !we;
        if (byt) begin
            p0.sel  = a[0] ? 2'b10 : 2'b01;
            p0.dat  = {wd[7:0], wd[7:0]};
            r.rdata = {8'h00, a[0] ? m0[15:8] : m0[7:0]};
            exp_ph.push_back(p0);
        end else if (!a[0]) begin
            p0.sel  = 2'b11;
            p0.dat  = wd;
            r.rdata = m0;
            exp_ph.push_back(p0);
        end else begin
            p0.sel  = 2'b10;
            p0.dat  = {wd[7:0], 8'h00};
            p1.sel  = 2'b01;
            p1.dat  = {8'h00, wd[15:8]};
            r.rdata = {m1[7:0], m0[15:8]};
            exp_ph.push_back(p0);
            exp_ph.push_back(p1);
        end
        exp_res.push_back(r);
    endtask

    // Each acknowledged phase is compared against the next expected one.
    always @(negedge clk) begin
        phase_t ph;
        if (!rst && sb_en && wb_cyc_o && wb_stb_o && wb_ack_i) begin
            if (exp_ph.size() == 0) begin
                check("phase_unexpected", 32'd1, 32'd0);
            end else begin
                ph = exp_ph.pop_front();
                check("ph_adr", {13'd0, wb_adr_o}, {13'd0, ph.adr});
                check("ph_sel", {30'd0, wb_sel_o}, {30'd0, ph.sel});
                check("ph_we_tgc", {30'd0, wb_we_o, wb_tgc_o}, {30'd0, ph.we, ph.tgc});
                if (ph.we)
                    check("ph_dat", {16'd0, wb_dat_o & lane_mask(ph.sel)},
                                    {16'd0, ph.dat & lane_mask(ph.sel)});
            end
        end
    end

    // Each rdy pulse retires the next expected result.
    always @(negedge clk) begin
        result_t r;
        if (!rst && (ex_rdy || if_rdy)) begin
            check("rdy_exclusive", {31'd0, ex_rdy & if_rdy}, 32'd0);
            check("rdy_one_cycle", {31'd0, ex_rdy ? prev_ex_rdy : prev_if_rdy}, 32'd0);
            if (exp_res.size() == 0) begin
                check("rdy_unexpected", 32'd1, 32'd0);
            end else begin
                r = exp_res.pop_front();
                check("rdy_source", {31'd0, ex_rdy}, {31'd0, r.is_ex});
                if (r.chk)
                    check("rdata", {16'd0, ex_rdy ? ex_rdata : if_rdata}, {16'd0, r.rdata});
            end
        end
        if (wb_cyc_o && !prev_cyc) n_starts <= n_starts + 1;
        n_rdy       <= n_rdy + int'(ex_rdy) + int'(if_rdy);
        prev_cyc    <= wb_cyc_o;
        prev_ex_rdy <= ex_rdy;
        prev_if_rdy <= if_rdy;
    end

    // ---------------- stimulus ----------------
    // lat = negedges from raising req to seeing rdy. scr scrambles the exec
    // inputs once the bus cycle is running (they are latched at grant).
    task automatic run_ex(input bit we, input bit io, input bit byt, input logic [19:0] a,
                          input logic [15:0] wd, input bit scr, input bit hold, output int lat);
        bit ok = 1'b0;
        lat = -1;
        @(negedge clk);
        ex_we = we; ex_m_io = io; ex_byte = byt; ex_addr = a; ex_wdata = wd; ex_req = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (ex_rdy) begin
                ok  = 1'b1;
                lat = i + 1;
            end else if (scr && wb_cyc_o) begin
                ex_we = ~we; ex_m_io = ~io; ex_byte = ~byt; ex_addr = ~a; ex_wdata = ~wd;
            end
        end
        check("ex_rdy_seen", {31'd0, ok}, 32'd1);
        if (hold) begin
            @(posedge clk);
            #1;
        end
        ex_req = 1'b0;
    endtask

    task automatic run_if(input logic [19:0] a, output int lat);
        bit ok = 1'b0;
        lat = -1;
        @(negedge clk);
        if_addr = a; if_req = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (if_rdy) begin
                ok  = 1'b1;
                lat = i + 1;
            end
        end
        check("if_rdy_seen", {31'd0, ok}, 32'd1);
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  lat, lat_if, s0, r0, ex_pos, if_pos;
        bit  both, ok;

        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
        mem[10'h1A2] = 16'hABCD;
        mem[10'h3FF] = 16'h11AA;
        mem[10'h000] = 16'h22BB;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus_ctl", {27'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_tgc_o, 1'b0},  32'd0);
        check("rst_sel_adr", {11'd0, wb_sel_o, wb_adr_o}, 32'd0);
        check("rst_dat_o",   {16'd0, wb_dat_o}, 32'd0);
        check("rst_rdata",   {ex_rdata, if_rdata}, 32'd0);
        check("rst_rdy",     {30'd0, ex_rdy, if_rdy}, 32'd0);
        rst = 1'b0;

        // Byte read, odd address, zero-wait: req cycle, stb cycle, rdy cycle
        push_expect(1, 0, 0, 1, 20'h12345, 16'h0000);
        run_ex(0, 0, 1, 20'h12345, 16'h0000, 1, 0, lat);
        check("t1_latency", lat, 32'd2);

        // Split word write, then read it back
        push_expect(1, 1, 0, 0, 20'h00101, 16'h1234);
        run_ex(1, 0, 0, 20'h00101, 16'h1234, 1, 0, lat);
        push_expect(1, 0, 0, 0, 20'h00101, 16'h0000);
        run_ex(0, 0, 0, 20'h00101, 16'h0000, 0, 0, lat);

        // IO byte write on the low lane, aligned word read
        push_expect(1, 1, 1, 1, 20'h00040, 16'h77EE);
        run_ex(1, 1, 1, 20'h00040, 16'h77EE, 1, 0, lat);
        push_expect(1, 0, 0, 0, 20'h00200, 16'h0000);
        run_ex(0, 0, 0, 20'h00200, 16'h0000, 0, 0, lat);

        // Fetch across the top of memory, and exec IO word across 0xFFFF
        push_expect(0, 0, 0, 0, 20'hFFFFF, 16'h0000);
        run_if(20'hFFFFF, lat);
        push_expect(1, 0, 1, 0, 20'hAFFFF, 16'h0000);
        run_ex(0, 1, 0, 20'hAFFFF, 16'h0000, 1, 0, lat);

        // Simultaneous requests, exec priority
        push_expect(1, 0, 0, 0, 20'h00300, 16'h0000);
        push_expect(0, 0, 0, 0, 20'h00400, 16'h0000);
        fork
            run_ex(0, 0, 0, 20'h00300, 16'h0000, 0, 0, lat);
            run_if(20'h00400, lat_if);
        join
        check("prio1_order", {31'd0, lat_if > lat}, 32'd1);

        // Simultaneous requests on the fetch-priority instance
        ex_we = 1'b0; ex_m_io = 1'b0; ex_byte = 1'b0; ex_addr = 20'h00010; if_addr = 20'h00020;
        both = 1'b0; ex_pos = -1; if_pos = -1;
        @(negedge clk);
        b_ex_req = 1'b1; b_if_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_ex_rdy && b_if_rdy) both = 1'b1;
            if (b_if_rdy) begin if_pos = i; b_if_req = 1'b0; end
            if (b_ex_rdy) begin ex_pos = i; b_ex_req = 1'b0; end
        end
        check("prio0_both_rdy", {31'd0, both}, 32'd0);
        check("prio0_order", {31'd0, (if_pos >= 0) && (ex_pos > if_pos)}, 32'd1);

        // Slow slave, request held through the rdy cycle
        ack_delay = 4;
        s0 = n_starts; r0 = n_rdy;
        push_expect(1, 0, 0, 0, 20'h00500, 16'h0000);
        run_ex(0, 0, 0, 20'h00500, 16'h0000, 0, 1, lat);
        check("t5_latency", lat, 32'd6);
        repeat (4) @(negedge clk);
        check("t5_bus_starts", n_starts - s0, 32'd1);
        check("t5_rdy_count", n_rdy - r0, 32'd1);

        // Reset during the HI phase of a split read
        ack_delay = 2;
        sb_en = 1'b0;
        r0 = n_rdy;
        ok = 1'b0;
        @(negedge clk);
        ex_we = 1'b0; ex_m_io = 1'b0; ex_byte = 1'b0; ex_addr = 20'h00301; ex_req = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_sel_o == 2'b01) ok = 1'b1;
        end
        check("t6_hi_reached", {31'd0, ok}, 32'd1);
        rst = 1'b1; ex_req = 1'b0;
        @(negedge clk);
        check("t6_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("t6_rdata_clr", {16'd0, ex_rdata}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_no_rdy", n_rdy - r0, 32'd0);
        sb_en = 1'b1;
        ack_delay = 0;
        push_expect(1, 0, 0, 0, 20'h00302, 16'h0000);
        run_ex(0, 0, 0, 20'h00302, 16'h0000, 0, 0, lat);
        check("t6_after_rst_lat", lat, 32'd2);

        repeat (3) @(negedge clk);
        check("sb_drained", exp_ph.size() + exp_res.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
